// File: rtl/cpu_clk_ctrl.sv
// Clock-enable sequencer for the board CPU: halt, free-run, single-step and
// N-pulse burst modes, all producing a one-cycle cpu_en in the clk domain.
//
// state   | meaning
// S_HALT  | idle, no pulses; waits for a mode or a step edge
// S_RUN   | free-run, one pulse every div+1 cycles
// S_STEP  | single cycle with cpu_en=1, then back to halt
// S_BURST | pulses every div+1 cycles until remaining reaches zero
module cpu_clk_ctrl #(
  parameter int DIV_W   = 32,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic               step_btn,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cnt_clr,
  output logic               cpu_en,
  output logic               busy,
  output logic [1:0]         state,
  output logic [31:0]        cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BURST = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt, div_cnt_d;
  logic [BURST_W-1:0] remaining, remaining_d;
  logic               btn_q;
  logic [31:0]        cycle_cnt_q;
  logic               step_fire;
  logic               tick;

  assign step_fire = step_btn & ~btn_q;
  // >= so that lowering div mid-count fires immediately instead of wrapping
  assign tick      = (div_cnt >= div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HALT;
      div_cnt     <= '0;
      remaining   <= '0;
      btn_q       <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt   <= div_cnt_d;
      remaining <= remaining_d;
      btn_q     <= step_btn;
      if (cnt_clr) begin
        cycle_cnt_q <= '0;
      end else if (cpu_en) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining;
    cpu_en      = 1'b0;
    case (state_q)
      S_HALT: begin
        if (mode == 2'b01) begin
          state_d = S_RUN;
        end else if (mode == 2'b10 && step_fire) begin
          state_d = S_STEP;
        end else if (mode == 2'b11 && step_fire && burst_len != '0) begin
          state_d     = S_BURST;
          remaining_d = burst_len;
        end
      end
      S_RUN: begin
        cpu_en = tick;
        if (mode != 2'b01) state_d = S_HALT;
      end
      S_STEP: begin
        cpu_en  = 1'b1;
        state_d = S_HALT;
      end
      S_BURST: begin
        // halt mode aborts and swallows any pulse due this cycle
        if (mode == 2'b00) begin
          state_d     = S_HALT;
          remaining_d = '0;
        end else begin
          cpu_en = tick && (remaining != '0);
          if (cpu_en) remaining_d = remaining - 1'b1;
          if (remaining == '0 || (cpu_en && remaining == 1)) state_d = S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // counter restarts from zero on every state entry
  always_comb begin
    div_cnt_d = '0;
    if ((state_q == S_RUN || state_q == S_BURST) && state_d == state_q) begin
      div_cnt_d = tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign busy      = (state_q == S_STEP) || (state_q == S_BURST);
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboarded bench for cpu_clk_ctrl: stimulus tasks predict pulse cycles
// arithmetically and a negedge monitor matches them against cpu_en.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] div = 32'd0;
  logic        step_btn = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        cnt_clr = 1'b0;
  logic        cpu_en;
  logic        busy;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] model_cnt = 32'd0;
  int          busy_lo = 1;
  int          busy_hi = 0;

  cpu_clk_ctrl #(.DIV_W(32), .BURST_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .div       (div),
    .step_btn  (step_btn),
    .burst_len (burst_len),
    .cnt_clr   (cnt_clr),
    .cpu_en    (cpu_en),
    .busy      (busy),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor: every expected pulse must appear exactly in its cycle
  always @(negedge clk) begin
    exp_t e;
    logic exp_b;
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_pulse: no cpu_en at cycle %0d, required one", expq[0].cyc);
      void'(expq.pop_front());
    end
    if (cpu_en === 1'b1) begin
      total++;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        if (cycle_cnt !== e.cnt) begin
          bad++;
          $display("FAIL pulse_cnt: cycle %0d cycle_cnt=%0d required %0d", cyc, cycle_cnt, e.cnt);
        end
      end else begin
        bad++;
        $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required 0", cyc);
      end
    end
    exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
    total++;
    if (busy !== exp_b) begin
      bad++;
      $display("FAIL busy: cycle %0d busy=%b required %b", cyc, busy, exp_b);
    end
  end

  task automatic step_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic do_run(input int d, input int len, input int clr_off);
    int k;
    int clr_c;
    bit p;
    mode = 2'b00;
    div = d;
    step_cyc(1);
    k = cyc;
    mode = 2'b01;
    clr_c = (clr_off < 0) ? -1 : k + clr_off;
    for (int c = k + 1; c <= k + len; c++) begin
      p = ((c - k) % (d + 1)) == 0;
      if (p) expq.push_back('{cyc: c, cnt: model_cnt});
      if (c == clr_c) model_cnt = 32'd0;
      else if (p) model_cnt = model_cnt + 32'd1;
    end
    for (int i = 1; i <= len; i++) begin
      step_cyc(1);
      cnt_clr = (cyc == clr_c);
      if (i == len) mode = 2'b00;
    end
    step_cyc(1);
    cnt_clr = 1'b0;
    check("run_exit_state", 32'(state), 32'd0);
    check("run_queue_empty", 32'(expq.size()), 32'd0);
    check("run_cycle_cnt", cycle_cnt, model_cnt);
  endtask

  task automatic do_step(input int hold);
    int k;
    mode = 2'b10;
    step_btn = 1'b0;
    step_cyc(1);
    step_btn = 1'b1;
    k = cyc;
    busy_lo = k + 1;
    busy_hi = k + 1;
    expq.push_back('{cyc: k + 1, cnt: model_cnt});
    model_cnt = model_cnt + 32'd1;
    step_cyc(hold);
    step_btn = 1'b0;
    step_cyc(2);
    check("step_state", 32'(state), 32'd0);
    check("step_queue_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic do_burst(input int len, input int d, input bit abort);
    int k;
    int n;
    int last;
    int mchg;
    mode = 2'b11;
    div = d;
    burst_len = 8'(len);
    step_btn = 1'b0;
    step_cyc(1);
    step_btn = 1'b1;
    k = cyc;
    n = abort ? 3 : len;
    for (int i = 1; i <= n; i++) begin
      expq.push_back('{cyc: k + i * (d + 1), cnt: model_cnt});
      model_cnt = model_cnt + 32'd1;
    end
    last = abort ? k + 3 * (d + 1) + 1 : k + len * (d + 1);
    busy_lo = k + 1;
    busy_hi = last;
    step_cyc(1);
    step_btn = 1'b0;
    burst_len = 8'($urandom_range(0, 255));
    if (!abort) begin
      mchg = k + 1 + $urandom_range(0, last - k - 1);
      while (cyc <= last) begin
        if (cyc == mchg) mode = 2'b10;
        step_cyc(1);
      end
    end else begin
      while (cyc < last) step_cyc(1);
      mode = 2'b00;
      step_cyc(1);
    end
    check("burst_end_state", 32'(state), 32'd0);
    step_cyc(4);
    check("burst_queue_empty", 32'(expq.size()), 32'd0);
    check("burst_cycle_cnt", cycle_cnt, model_cnt);
    mode = 2'b00;
  endtask

  task automatic do_burst_zero();
    mode = 2'b11;
    burst_len = 8'd0;
    step_btn = 1'b0;
    step_cyc(1);
    step_btn = 1'b1;
    step_cyc(3);
    check("burst0_state", 32'(state), 32'd0);
    step_btn = 1'b0;
    step_cyc(3);
    check("burst0_state_after", 32'(state), 32'd0);
    mode = 2'b00;
  endtask

  task automatic do_reset_mid_run();
    int k;
    int e;
    mode = 2'b00;
    div = 32'd2;
    step_cyc(1);
    k = cyc;
    mode = 2'b01;
    e = k + $urandom_range(7, 15);
    for (int c = k + 1; c <= e - 1; c++) begin
      if (((c - k) % 3) == 0) begin
        expq.push_back('{cyc: c, cnt: model_cnt});
        model_cnt = model_cnt + 32'd1;
      end
    end
    while (cyc < e) step_cyc(1);
    #1 rst = 1'b0;
    #1;
    model_cnt = 32'd0;
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_queue_empty", 32'(expq.size()), 32'd0);
    mode = 2'b00;
    step_cyc(2);
    rst = 1'b1;
    step_cyc(20);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_cycle_cnt", cycle_cnt, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int len;
    int d;
    rst = 1'b0;
    step_cyc(3);
    check("init_state", 32'(state), 32'd0);
    check("init_cpu_en", 32'(cpu_en), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_cycle_cnt", cycle_cnt, 32'd0);
    rst = 1'b1;
    step_cyc(2);

    do_run(3, 40, -1);
    check("free_run_ten", cycle_cnt, 32'd10);
    do_run(0, 10, -1);
    do_run(0, 12, 5);
    do_run(2, 20, 4);

    do_step(10);
    do_step(10);

    do_burst(5, 1, 1'b0);
    do_burst_zero();

    cnt_clr = 1'b1;
    step_cyc(1);
    cnt_clr = 1'b0;
    model_cnt = 32'd0;
    do_burst(200, 4, 1'b1);
    check("abort_cycle_cnt", cycle_cnt, 32'd3);
    do_burst(200, 0, 1'b1);

    do_reset_mid_run();

    for (int it = 0; it < 12; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin
          len = $urandom_range(5, 40);
          d = $urandom_range(0, 7);
          do_run(d, len, ($urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : -1);
        end
        1: do_step($urandom_range(2, 6));
        2: begin
          len = $urandom_range(1, 12);
          do_burst(len, $urandom_range(0, 4), (len > 3) && ($urandom_range(0, 1) == 1));
        end
        default: do_burst_zero();
      endcase
    end

    step_cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
